deadline_arbiter: RTL and testbench

Parametrised successor to the fixed-priority queue arbiter. It selects which of `NUMBER_OF_QUEUES` memory request queues is served next. It runs in one of two modes: fixed priority (FP) or earliest-deadline-first (EDF). In EDF mode it keeps a per-queue absolute-deadline down-counter and raises a sticky deadline-miss flag per queue. It sits between the per-core request queues and the memory-side port, and it adds a valid/ready handshake that the plain FP arbiter lacks.

---
 rtl/deadline_arbiter.sv | 118 +++++++++++
 tb/tb_deadline_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/deadline_arbiter.sv
// deadline_arbiter: picks the next memory request queue to serve, either by
// fixed priority (larger priority wins) or earliest deadline first (smallest
// remaining deadline wins). Tracks a per-queue deadline down-counter and a
// sticky deadline-miss flag, and presents the grant over a valid/ready pair.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - asynchronous active-high reset
//   mode       - 0 = fixed priority, 1 = earliest deadline first
//   priorities - per-queue priority (FP) or relative deadline in cycles (EDF)
//   free       - bit i set means queue i is empty (not requesting)
//   ready      - downstream accepts the current selection
//   selection  - registered granted queue index
//   valid      - selection is meaningful
//   missed     - sticky per-queue deadline-miss flags
module deadline_arbiter #(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned REGISTER_SIZE    = 32,
  parameter int unsigned SEL_WIDTH        = $clog2(NUMBER_OF_QUEUES)
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           mode,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] priorities,
  input  logic [NUMBER_OF_QUEUES-1:0]                    free,
  input  logic                                           ready,
  output logic [SEL_WIDTH-1:0]                           selection,
  output logic                                           valid,
  output logic [NUMBER_OF_QUEUES-1:0]                    missed
);

  localparam int unsigned NQ = NUMBER_OF_QUEUES;
  localparam int unsigned RW = REGISTER_SIZE;

  logic [NQ-1:0]          armed;
  logic [NQ-1:0][RW-1:0]  d;

  logic [NQ-1:0]          served_c;
  logic [NQ-1:0]          eligible_c;
  logic [NQ-1:0][RW-1:0]  key_c;
  logic                   any_c;
  logic [SEL_WIDTH-1:0]   winner_c;
  logic [RW-1:0]          best_c;

  // Served / eligible masks and per-queue comparison keys.
  // The served queue is masked out so it cannot be re-granted before its
  // free bit has had a chance to update.
  always_comb begin
    served_c   = '0;
    eligible_c = '0;
    key_c      = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      served_c[i]   = valid && ready && (selection == SEL_WIDTH'(i));
      eligible_c[i] = !free[i] && !served_c[i];
      key_c[i]      = (mode && armed[i]) ? d[i] : priorities[i];
    end
  end

  // Linear scan; strict comparison keeps ties on the lowest index.
  always_comb begin
    any_c    = 1'b0;
    winner_c = '0;
    best_c   = '0;
    for (int unsigned i = 0; i < NQ; i++) begin
      if (eligible_c[i]) begin
        if (!any_c || (mode ? (key_c[i] < best_c) : (key_c[i] > best_c))) begin
          any_c    = 1'b1;
          winner_c = SEL_WIDTH'(i);
          best_c   = key_c[i];
        end
      end
    end
  end

  // Per-queue deadline state; service outranks arming and countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      armed  <= '0;
      d      <= '0;
      missed <= '0;
    end else begin
      for (int unsigned i = 0; i < NQ; i++) begin
        if (served_c[i]) begin
          missed[i] <= 1'b0;
          if (!free[i]) begin
            d[i]     <= priorities[i];
            armed[i] <= 1'b1;
          end else begin
            armed[i] <= 1'b0;
          end
        end else if (!armed[i]) begin
          if (!free[i]) begin
            d[i]     <= priorities[i];
            armed[i] <= 1'b1;
          end
        end else if (d[i] != '0) begin
          d[i] <= d[i] - RW'(1);
        end else begin
          missed[i] <= 1'b1;
        end
      end
    end
  end

  // Grant register: load a fresh decision unless a grant is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      selection <= '0;
      valid     <= 1'b0;
    end else if (!valid || ready) begin
      valid <= any_c;
      if (any_c) begin
        selection <= winner_c;
      end
    end
  end

endmodule

// File: tb/tb_deadline_arbiter.sv
// tb_deadline_arbiter: directed scenarios plus randomized traffic, checked by
// a scoreboard fed from a behavioural model of the arbiter.
module tb_deadline_arbiter;

  localparam int NQ = 4;
  localparam int RW = 32;
  localparam int SW = 2;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   mode = 1'b0;
  logic [NQ-1:0][RW-1:0]  priorities = '0;
  logic [NQ-1:0]          free = '1;
  logic                   ready = 1'b0;
  logic [SW-1:0]          selection;
  logic                   valid;
  logic [NQ-1:0]          missed;

  deadline_arbiter #(
    .NUMBER_OF_QUEUES(NQ),
    .REGISTER_SIZE(RW),
    .SEL_WIDTH(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mode(mode),
    .priorities(priorities),
    .free(free),
    .ready(ready),
    .selection(selection),
    .valid(valid),
    .missed(missed)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          v;
    logic [SW-1:0] s;
    logic [NQ-1:0] m;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit          m_armed[NQ];
  logic [RW-1:0] m_d[NQ];
  bit          m_missed[NQ];
  bit          m_valid;
  int          m_sel;

  function automatic void model_reset();
    for (int i = 0; i < NQ; i++) begin
      m_armed[i]  = 0;
      m_d[i]      = '0;
      m_missed[i] = 0;
    end
    m_valid = 0;
    m_sel   = 0;
  endfunction

  // Urgency of queue i for the current mode; the winner is found by picking
  // the first requesting queue with the best urgency.
  function automatic logic [RW-1:0] urgency(int i);
    if (mode == 1'b1 && m_armed[i]) return m_d[i];
    return priorities[i];
  endfunction

  // Advance the model by one rising edge using the currently driven inputs.
  function automatic void model_step();
    int served;
    int cand[$];
    int win;
    if (reset) begin
      model_reset();
      return;
    end
    served = (m_valid && ready) ? m_sel : -1;
    for (int i = 0; i < NQ; i++)
      if (!free[i] && i != served) cand.push_back(i);
    win = -1;
    foreach (cand[j]) begin
      if (win < 0) win = cand[j];
      else if (mode == 1'b0 && urgency(cand[j]) > urgency(win)) win = cand[j];
      else if (mode == 1'b1 && urgency(cand[j]) < urgency(win)) win = cand[j];
    end
    for (int i = 0; i < NQ; i++) begin
      if (i == served) begin
        m_missed[i] = 0;
        m_armed[i]  = !free[i];
        if (!free[i]) m_d[i] = priorities[i];
      end else if (!m_armed[i]) begin
        if (!free[i]) begin
          m_armed[i] = 1;
          m_d[i]     = priorities[i];
        end
      end else if (m_d[i] > 0) begin
        m_d[i] = m_d[i] - 1;
      end else begin
        m_missed[i] = 1;
      end
    end
    if (!m_valid || ready) begin
      m_valid = (win >= 0);
      if (win >= 0) m_sel = win;
    end
  endfunction

  task automatic push_expect();
    exp_t e;
    e.v = m_valid;
    e.s = SW'(m_sel);
    for (int i = 0; i < NQ; i++) e.m[i] = m_missed[i];
    exp_q.push_back(e);
  endtask

  // One clock: predict, then advance to the next falling edge.
  task automatic cycle();
    model_step();
    push_expect();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_prio(input int p0, input int p1, input int p2, input int p3);
    priorities[0] = RW'(p0);
    priorities[1] = RW'(p1);
    priorities[2] = RW'(p2);
    priorities[3] = RW'(p3);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic async_reset();
    #1;
    reset = 1'b1;
    #1;
    check("async_valid", valid, 0);
    check("async_missed", missed, 0);
    check("async_sel", selection, 0);
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({valid, selection, missed} !== e) begin
          errors++;
          $display("FAIL grant t=%0t actual v=%b sel=%0d missed=%b expected v=%b sel=%0d missed=%b",
                   $time, valid, selection, missed, e.v, e.s, e.m);
        end
      end
    end
  end

  initial begin
    model_reset();
    cycle();
    cycle();
    check("reset_valid", valid, 0);
    check("reset_missed", missed, 0);
    reset = 1'b0;

    // Fixed-priority ordering.
    mode = 1'b0;
    set_prio(15, 14, 13, 12);
    ready = 1'b1;
    free = 4'b1110; cycle(); check("fp_sel0", selection, 0); check("fp_valid0", valid, 1);
    free = 4'b1101; cycle(); check("fp_sel1", selection, 1);
    free = 4'b1100; cycle(); check("fp_sel2", selection, 0);
    free = 4'b1001; cycle();
    cycle();

    // Hold under backpressure while priorities change.
    do_reset();
    mode = 1'b0;
    set_prio(15, 14, 13, 12);
    free = 4'b0000;
    ready = 1'b0;
    cycle();
    check("hold_sel_start", selection, 0);
    repeat (2) cycle();
    priorities[3] = RW'(99);
    repeat (3) cycle();
    check("hold_sel", selection, 0);
    check("hold_valid", valid, 1);
    ready = 1'b1;
    cycle();
    check("hold_release_sel", selection, 3);

    // Earliest-deadline-first ordering.
    do_reset();
    mode = 1'b1;
    set_prio(8, 3, 5, 10);
    free = 4'b0000;
    ready = 1'b1;
    cycle(); check("edf_first", selection, 1);
    cycle(); check("edf_second", selection, 2);
    repeat (6) cycle();

    // Deadline miss on queue 2 while queue 0 holds the grant.
    do_reset();
    mode = 1'b1;
    set_prio(1, 50, 2, 50);
    ready = 1'b0;
    free = 4'b1110; cycle();
    free = 4'b1010; cycle();
    cycle();
    cycle(); check("miss_before", missed[2], 0);
    cycle(); check("miss_rise", missed[2], 1);
    ready = 1'b1;
    cycle(); check("miss_grant_q2", selection, 2); check("miss_still", missed[2], 1);
    cycle(); check("miss_clear", missed[2], 0);

    // Tie in EDF, then switch to fixed priority.
    do_reset();
    mode = 1'b1;
    set_prio(5, 5, 5, 5);
    free = 4'b0000;
    ready = 1'b1;
    cycle(); check("tie_sel", selection, 0);
    mode = 1'b0;
    set_prio(1, 2, 3, 4);
    cycle(); check("switch_sel", selection, 3);
    repeat (3) cycle();

    // Asynchronous reset with a live grant.
    check("pre_async_valid", valid, 1);
    async_reset();
    cycle();
    check("post_async_valid", valid, 1);
    check("post_async_sel", selection, 3);

    // Randomized traffic.
    for (int i = 0; i < NQ; i++) priorities[i] = RW'($urandom_range(0, 6));
    for (int n = 0; n < 600; n++) begin
      free  = NQ'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) priorities[$urandom_range(0, NQ-1)] = RW'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) async_reset();
      else cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
